// File: rtl/io_trap_queue.sv
`default_nettype none
// ============================================================================
// Module   : io_trap_queue
// Purpose  : FIFO of trapped guest I/O cycles with NMI sequencing to the host.
// Revision : 1.0  initial release
// ============================================================================
module io_trap_queue #(
    parameter int ADDR_W     = 16,
    parameter int DEPTH      = 4,
    parameter int NMI_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       trap_enable,
    input  logic                       viol_valid,
    input  logic [ADDR_W-1:0]          viol_addr,
    input  logic [7:0]                 viol_data,
    input  logic                       viol_write,
    input  logic                       pop,
    input  logic                       untrap,
    input  logic                       flush,
    output logic [ADDR_W-1:0]          head_addr,
    output logic [7:0]                 head_data,
    output logic                       head_write,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       trap_state,
    output logic                       nmi_n
);

    localparam int PW      = $clog2(DEPTH);
    localparam int CNT_W   = PW + 1;
    localparam int CW      = (NMI_CYCLES > 1) ? $clog2(NMI_CYCLES) : 1;
    localparam int ENTRY_W = ADDR_W + 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_NMI     = 2'd1,
        ST_TRAPPED = 2'd2
    } state_t;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [ENTRY_W-1:0] head_q, head_d;

    state_t             state_q;
    logic [CW-1:0]      nmi_cnt_q;
    logic               nmi_n_q;
    logic               trap_state_q;

    logic               is_full;
    logic               is_empty;
    logic               push_req;
    logic               do_push;
    logic               do_pop;
    logic [ENTRY_W-1:0] new_entry;

    always_comb begin
        is_full   = (count_q == CNT_W'(DEPTH));
        is_empty  = (count_q == '0);
        push_req  = viol_valid & trap_enable;
        // A pop frees the slot in the same cycle, so a full FIFO can still accept.
        do_push   = push_req & (~is_full | pop) & ~flush;
        do_pop    = pop & ~is_empty & ~flush;
        new_entry = {viol_addr, viol_data, viol_write};

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        head_d     = head_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
            if (push_req && is_full && !pop) overflow_d = 1'b1;
        end

        // The new head may be the entry being written this very cycle.
        if (count_d != '0) begin
            if (do_push && (rd_ptr_d == wr_ptr_q)) head_d = new_entry;
            else                                   head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= new_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            head_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            head_q     <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            nmi_cnt_q    <= '0;
            nmi_n_q      <= 1'b1;
            trap_state_q <= 1'b0;
        end else if (!trap_enable) begin
            state_q      <= ST_IDLE;
            nmi_n_q      <= 1'b1;
            trap_state_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (do_push || !is_empty) begin
                        state_q      <= ST_NMI;
                        nmi_cnt_q    <= CW'(NMI_CYCLES - 1);
                        nmi_n_q      <= 1'b0;
                        trap_state_q <= 1'b1;
                    end
                end
                ST_NMI: begin
                    if (nmi_cnt_q == '0) begin
                        state_q <= ST_TRAPPED;
                        nmi_n_q <= 1'b1;
                    end else begin
                        nmi_cnt_q <= nmi_cnt_q - CW'(1);
                    end
                end
                ST_TRAPPED: begin
                    if (untrap) begin
                        if (count_d != '0) begin
                            state_q   <= ST_NMI;
                            nmi_cnt_q <= CW'(NMI_CYCLES - 1);
                            nmi_n_q   <= 1'b0;
                        end else begin
                            state_q      <= ST_IDLE;
                            trap_state_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    nmi_n_q      <= 1'b1;
                    trap_state_q <= 1'b0;
                end
            endcase
        end
    end

    assign head_addr  = head_q[ENTRY_W-1:9];
    assign head_data  = head_q[8:1];
    assign head_write = head_q[0];
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign overflow   = overflow_q;
    assign trap_state = trap_state_q;
    assign nmi_n      = nmi_n_q;

endmodule
`default_nettype wire

// File: tb/tb_io_trap_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_trap_queue
// Purpose  : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0  initial release
// ============================================================================
module tb_io_trap_queue;

    localparam int NMI_LEN = 8;
    localparam int QDEPTH  = 4;

    logic        clk;
    logic        reset;
    logic        trap_enable;
    logic        viol_valid;
    logic [15:0] viol_addr;
    logic [7:0]  viol_data;
    logic        viol_write;
    logic        pop;
    logic        untrap;
    logic        flush;
    logic [15:0] head_addr;
    logic [7:0]  head_data;
    logic        head_write;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        trap_state;
    logic        nmi_n;

    io_trap_queue #(.ADDR_W(16), .DEPTH(QDEPTH), .NMI_CYCLES(NMI_LEN)) dut (
        .clk(clk), .reset(reset), .trap_enable(trap_enable),
        .viol_valid(viol_valid), .viol_addr(viol_addr), .viol_data(viol_data),
        .viol_write(viol_write), .pop(pop), .untrap(untrap), .flush(flush),
        .head_addr(head_addr), .head_data(head_data), .head_write(head_write),
        .count(count), .empty(empty), .full(full), .overflow(overflow),
        .trap_state(trap_state), .nmi_n(nmi_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queue of {addr,data,write}, mode 0=idle 1=nmi 2=trapped.
    logic [24:0] mq[$];
    logic [24:0] mhead = '0;
    bit          movf  = 1'b0;
    int          mmode = 0;
    int          mleft = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  pre;
        bit  push;
        if (reset) begin
            mq.delete(); mhead = '0; movf = 0; mmode = 0; mleft = 0;
            return;
        end
        pre  = mq.size();
        push = viol_valid && trap_enable && (pre < QDEPTH || pop) && !flush;
        if (flush) begin
            mq.delete();
            movf = 0;
        end else begin
            if (viol_valid && trap_enable && pre == QDEPTH && !pop) movf = 1;
            if (pop && pre > 0) void'(mq.pop_front());
            if (push) mq.push_back({viol_addr, viol_data, viol_write});
        end
        if (mq.size() > 0) mhead = mq[0];
        if (!trap_enable) mmode = 0;
        else case (mmode)
            0: if (push || pre > 0) begin mmode = 1; mleft = NMI_LEN; end
            1: begin mleft--; if (mleft == 0) mmode = 2; end
            default: if (untrap) begin
                if (mq.size() > 0) begin mmode = 1; mleft = NMI_LEN; end
                else mmode = 0;
            end
        endcase
    endtask

    task automatic compare_model();
        chk("m_count",      count,      mq.size());
        chk("m_empty",      empty,      mq.size() == 0);
        chk("m_full",       full,       mq.size() == QDEPTH);
        chk("m_overflow",   overflow,   movf);
        chk("m_trap_state", trap_state, mmode != 0);
        chk("m_nmi_n",      nmi_n,      mmode != 1);
        chk("m_head_addr",  head_addr,  mhead[24:9]);
        chk("m_head_data",  head_data,  mhead[8:1]);
        chk("m_head_write", head_write, mhead[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        compare_model();
        reset = 0; viol_valid = 0; pop = 0; untrap = 0; flush = 0;
    endtask

    task automatic strobe(input logic [15:0] a, input logic [7:0] d, input logic w);
        viol_valid = 1; viol_addr = a; viol_data = d; viol_write = w;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
    endtask

    typedef struct {
        bit          v;
        logic [15:0] addr;
        logic [7:0]  data;
        bit          wr;
        bit          p;
        bit          ut;
        logic [2:0]  e_count;
        bit          e_nmi_n;
        bit          e_trap;
        logic [15:0] e_head;
    } vec_t;

    vec_t tbl[11];

    initial begin : main
        int n_low;
        logic [15:0] exp_seq [4];

        reset = 1; trap_enable = 0; viol_valid = 0; viol_addr = '0; viol_data = '0;
        viol_write = 0; pop = 0; untrap = 0; flush = 0;

        // Single trap: strobe, 8-cycle NMI, trapped, pop, untrap.
        tbl[0]  = '{1, 16'h00A0, 8'h5A, 1, 0, 0, 3'd1, 0, 1, 16'h00A0};
        for (int i = 1; i < 8; i++)
            tbl[i] = '{0, 16'h0000, 8'h00, 0, 0, 0, 3'd1, 0, 1, 16'h00A0};
        tbl[8]  = '{0, 16'h0000, 8'h00, 0, 0, 0, 3'd1, 1, 1, 16'h00A0};
        tbl[9]  = '{0, 16'h0000, 8'h00, 0, 1, 0, 3'd0, 1, 1, 16'h00A0};
        tbl[10] = '{0, 16'h0000, 8'h00, 0, 0, 1, 3'd0, 1, 0, 16'h00A0};

        // Reset state
        tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_trap_state", trap_state, 0);
        chk("rst_nmi_n", nmi_n, 1);
        chk("rst_head_addr", head_addr, 0);

        trap_enable = 1;
        for (int i = 0; i < 11; i++) begin
            viol_valid = tbl[i].v; viol_addr = tbl[i].addr; viol_data = tbl[i].data;
            viol_write = tbl[i].wr; pop = tbl[i].p; untrap = tbl[i].ut;
            tick();
            chk($sformatf("tbl%0d_count", i), count, tbl[i].e_count);
            chk($sformatf("tbl%0d_nmi_n", i), nmi_n, tbl[i].e_nmi_n);
            chk($sformatf("tbl%0d_trap", i), trap_state, tbl[i].e_trap);
            chk($sformatf("tbl%0d_head", i), head_addr, tbl[i].e_head);
        end
        chk("single_head_data", head_data, 8'h5A);
        chk("single_head_write", head_write, 1);
        chk("single_empty", empty, 1);

        // Overflow then drain then flush
        do_reset();
        trap_enable = 1;
        for (int i = 0; i < 5; i++) begin
            strobe(16'h0010 + 16'(i), 8'(i), 1'(i));
            tick();
        end
        chk("ovf_full", full, 1);
        chk("ovf_overflow", overflow, 1);
        chk("ovf_count", count, 4);
        chk("ovf_head", head_addr, 16'h0010);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_head", head_addr, 16'h0010 + 16'(i));
            pop = 1;
            tick();
        end
        chk("ovf_drained_empty", empty, 1);
        chk("ovf_still_sticky", overflow, 1);
        flush = 1;
        tick();
        chk("flush_clears_ovf", overflow, 0);

        // Re-arm after untrap with an entry still queued
        do_reset();
        trap_enable = 1;
        strobe(16'h0030, 8'h11, 0); tick();
        strobe(16'h0031, 8'h22, 1); tick();
        for (int i = 0; i < 10; i++) tick();
        chk("rearm_trapped", trap_state, 1);
        chk("rearm_nmi_idle_hi", nmi_n, 1);
        chk("rearm_count2", count, 2);
        pop = 1; tick();
        chk("rearm_head2", head_addr, 16'h0031);
        untrap = 1; tick();
        n_low = (nmi_n == 1'b0) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (nmi_n == 1'b0) n_low++;
        end
        chk("rearm_nmi_len", n_low, NMI_LEN);
        pop = 1; untrap = 1; tick();
        chk("rearm_back_idle", trap_state, 0);
        chk("rearm_empty", empty, 1);

        // Simultaneous push and pop while full
        do_reset();
        trap_enable = 1;
        for (int i = 0; i < 4; i++) begin
            strobe(16'h0020 + 16'(i), 8'hC0 + 8'(i), 0);
            tick();
        end
        chk("pp_full", full, 1);
        strobe(16'h0077, 8'h77, 1); pop = 1; tick();
        chk("pp_count", count, 4);
        chk("pp_no_ovf", overflow, 0);
        exp_seq[0] = 16'h0021; exp_seq[1] = 16'h0022;
        exp_seq[2] = 16'h0023; exp_seq[3] = 16'h0077;
        for (int k = 0; k < 4; k++) begin
            chk("pp_order", head_addr, exp_seq[k]);
            pop = 1;
            tick();
        end

        // Disable mid-NMI, then reset
        do_reset();
        trap_enable = 1;
        strobe(16'h0040, 8'h44, 1); tick();
        tick(); tick();
        chk("dis_in_nmi", nmi_n, 0);
        trap_enable = 0; tick();
        chk("dis_nmi_n", nmi_n, 1);
        chk("dis_trap_state", trap_state, 0);
        chk("dis_count_kept", count, 1);
        trap_enable = 1; strobe(16'h0041, 8'h45, 0); reset = 1; tick();
        chk("rst2_count", count, 0);
        chk("rst2_nmi_n", nmi_n, 1);
        chk("rst2_trap", trap_state, 0);
        chk("rst2_head", head_addr, 0);
        chk("rst2_overflow", overflow, 0);

        // Randomised run against the model
        for (int i = 0; i < 1500; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            trap_enable = ($urandom_range(0, 15) != 0);
            viol_valid  = ($urandom_range(0, 2) == 0);
            viol_addr   = 16'($urandom);
            viol_data   = 8'($urandom);
            viol_write  = 1'($urandom);
            pop         = ($urandom_range(0, 3) == 0);
            untrap      = ($urandom_range(0, 5) == 0);
            flush       = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
